fcvt_wb_buffer: RTL and testbench

- In-order writeback buffer that sits directly downstream of the itof conversion pipeline.
- The itof pipeline has no stall input and carries no destination tag. This block pairs each itof result with the destination tag captured at issue time.
- Results are held in a small FIFO and presented to the register-file writeback port through a valid/ready handshake.
- Issue is credit-gated, so an itof result can never arrive when no slot is free.

---
 rtl/fcvt_pkg.sv | 15 +
 rtl/fcvt_wb_buffer.sv | 117 +++++++++++
 tb/tb_fcvt_wb_buffer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcvt_pkg.sv
// Shared types and default sizes for the itof writeback path.
package fcvt_pkg;

  localparam int FCVT_TAG_W    = 5;
  localparam int FCVT_DATA_W   = 32;
  localparam int FCVT_WB_DEPTH = 4;

  // One writeback slot: destination tag, converted result, result-present flag.
  typedef struct packed {
    logic [FCVT_TAG_W-1:0]  tag;
    logic [FCVT_DATA_W-1:0] data;
    logic                   filled;
  } wb_entry_t;

endpackage

// File: rtl/fcvt_wb_buffer.sv
// In-order writeback buffer behind the itof pipeline.
// A slot is allocated at issue (tag captured), filled when the matching
// result comes out of itof, and drained through a valid/ready port.
// Slots are filled strictly in issue order because itof is in-order.
module fcvt_wb_buffer
  import fcvt_pkg::*;
#(
  parameter int DEPTH  = FCVT_WB_DEPTH,
  parameter int TAG_W  = FCVT_TAG_W,
  parameter int DATA_W = FCVT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [TAG_W-1:0]       issue_tag,
  output logic                   issue_ready,
  input  logic                   res_valid,
  input  logic [DATA_W-1:0]      res_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [TAG_W-1:0]       wb_tag,
  output logic [DATA_W-1:0]      wb_data,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] fill_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic full;
  logic issue_fire;
  logic res_pending;
  logic res_fire;
  logic pop_fire;

  assign full       = (cnt_q == FULL_CNT);
  assign issue_fire = issue_valid && !full;

  // When full, wr_ptr aliases rd_ptr, so fill_ptr == wr_ptr can mean either
  // "everything filled" or "nothing filled"; the slot's filled bit decides.
  assign res_pending = (fill_ptr_q != wr_ptr_q) || (full && !mem_q[fill_ptr_q].filled);
  assign res_fire    = res_valid && res_pending;

  assign pop_fire    = wb_valid && wb_ready;

  assign issue_ready = !full;
  assign wb_valid    = mem_q[rd_ptr_q].filled && (cnt_q != '0);
  assign wb_tag      = mem_q[rd_ptr_q].tag;
  assign wb_data     = mem_q[rd_ptr_q].data;
  assign outstanding = cnt_q;
  assign err         = err_q;

  // Slot storage: issue, fill and pop always touch distinct slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (issue_fire) begin
        mem_q[wr_ptr_q].tag    <= issue_tag;
        mem_q[wr_ptr_q].filled <= 1'b0;
      end
      if (res_fire) begin
        mem_q[fill_ptr_q].data   <= res_data;
        mem_q[fill_ptr_q].filled <= 1'b1;
      end
      if (pop_fire) begin
        mem_q[rd_ptr_q].filled <= 1'b0;
      end
    end
  end

  // Pointer advance; all three wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (issue_fire) wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (res_fire)   fill_ptr_q <= fill_ptr_q + 1'b1;
      if (pop_fire)   rd_ptr_q   <= rd_ptr_q + 1'b1;
    end
  end

  // Occupancy: simultaneous issue and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      case ({issue_fire, pop_fire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky flag for a result that arrives with no slot waiting for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (res_valid && !res_pending) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fcvt_wb_buffer.sv
// Bench for fcvt_wb_buffer. The itof pipeline is stood in for by a fixed
// latency delay line carrying a behavioural int->float conversion; the
// buffer itself is checked every cycle against a queue model.
module tb_fcvt_wb_buffer;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_tag;
  logic        issue_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic [2:0]  outstanding;
  logic        err;

  int          issue_in;
  logic        force_res;
  logic [31:0] force_data;

  logic        pv [LAT];
  logic [31:0] pd [LAT];

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    bit          filled;
  } ment_t;

  ment_t mq[$];
  bit    m_err;
  int    n_acc;
  int    n_vec;
  int    n_miss;

  always #5 clk = ~clk;

  fcvt_wb_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .outstanding (outstanding),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Signed 32-bit integer to IEEE-754 single, round to nearest even.
  function automatic logic [31:0] itof(input int x);
    logic [63:0] m, mant, rem, half;
    int p, s;
    logic [7:0] e;
    if (x == 0) return 32'h0;
    m = (x < 0) ? 64'(-longint'(x)) : 64'(longint'(x));
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p <= 23) begin
      mant = m << (23 - p);
    end else begin
      s    = p - 23;
      mant = m >> s;
      rem  = m - (mant << s);
      half = 64'd1 << (s - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        p    = p + 1;
      end
    end
    e = 8'(127 + p);
    return {(x < 0), e, mant[22:0]};
  endfunction

  // One clock: update model from pre-edge inputs, advance the itof stand-in,
  // then compare every DUT output against the model on the falling edge.
  task automatic step();
    bit m_rdy, m_wbv, found, acc;
    @(posedge clk);
    m_rdy = (mq.size() < DEPTH);
    m_wbv = (mq.size() > 0) && mq[0].filled;
    acc   = !rst && issue_valid && m_rdy;
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (res_valid) begin
        found = 1'b0;
        foreach (mq[i]) begin
          if (!found && !mq[i].filled) begin
            mq[i].data   = res_data;
            mq[i].filled = 1'b1;
            found        = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
      if (m_wbv && wb_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{issue_tag, 32'h0, 1'b0});
        n_acc++;
      end
    end
    // The decoder raises itof input_valid only for accepted issues.
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0;
        pd[i] = 32'h0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = acc;
      pd[0] = itof(issue_in);
    end
    #1;
    res_valid = pv[LAT-1] | force_res;
    res_data  = force_res ? force_data : pd[LAT-1];
    @(negedge clk);
    chk("issue_ready", issue_ready, (mq.size() < DEPTH));
    chk("wb_valid", wb_valid, (mq.size() > 0) && mq[0].filled);
    chk("outstanding", outstanding, mq.size());
    chk("err", err, m_err);
    if (mq.size() > 0 && mq[0].filled) begin
      chk("wb_tag", wb_tag, mq[0].tag);
      chk("wb_data", wb_data, mq[0].data);
    end
  endtask

  task automatic wait_wbv(input int n);
    int k = 0;
    while (!wb_valid && k < n) begin
      step();
      k++;
    end
    if (!wb_valid) chk("wbv_timeout", wb_valid, 1);
  endtask

  task automatic drain();
    int k = 0;
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    while (mq.size() > 0 && k < 40) begin
      step();
      k++;
    end
    if (mq.size() > 0) chk("drain_timeout", outstanding, 0);
    wb_ready = 1'b0;
  endtask

  int          t2_in  [4] = '{0, 1, -1, 16777217};
  logic [31:0] t2_exp [4] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h4B800000};

  initial begin
    int start, guard;
    rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; wb_ready = 1'b0;
    issue_in = 0; force_res = 1'b0; force_data = '0;
    res_valid = 1'b0; res_data = '0; m_err = 1'b0;
    n_acc = 0; n_vec = 0; n_miss = 0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = 32'h0;
    end
    step(); step();
    rst = 1'b0;
    chk("rst_ready", issue_ready, 1);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_err", err, 0);

    // Single issue
    issue_valid = 1'b1; issue_tag = 5'd3; issue_in = 100;
    step();
    issue_valid = 1'b0;
    wait_wbv(10);
    chk("t1_tag", wb_tag, 3);
    chk("t1_data", wb_data, 32'h42C80000);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("t1_out", outstanding, 0);
    chk("t1_wbv", wb_valid, 0);

    // Back-to-back fill to full, then ordered drain
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_tag = 5'(i + 1); issue_in = t2_in[i];
      step();
    end
    issue_valid = 1'b0;
    chk("t2_ready", issue_ready, 0);
    chk("t2_out", outstanding, 4);
    repeat (LAT + 1) step();
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_wbv", wb_valid, 1);
      chk("t2_tag", wb_tag, i + 1);
      chk("t2_data", wb_data, t2_exp[i]);
      step();
    end
    wb_ready = 1'b0;
    chk("t2_empty", outstanding, 0);

    // Full with simultaneous issue and pop: issue is dropped
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_tag = 5'(8 + i); issue_in = 5 + i;
      step();
    end
    issue_valid = 1'b0;
    repeat (LAT + 1) step();
    chk("t3_full", outstanding, 4);
    issue_valid = 1'b1; issue_tag = 5'd12; issue_in = 99; wb_ready = 1'b1;
    step();
    issue_valid = 1'b0; wb_ready = 1'b0;
    chk("t3_out", outstanding, 3);
    chk("t3_ready", issue_ready, 1);
    chk("t3_tag", wb_tag, 9);
    drain();

    // Pointer wrap under random backpressure
    start = n_acc;
    guard = 0;
    while (n_acc - start < 20 && guard < 400) begin
      issue_valid = 1'b1;
      issue_tag   = 5'($urandom);
      issue_in    = int'($urandom);
      wb_ready    = 1'($urandom);
      step();
      guard++;
    end
    if (n_acc - start < 20) chk("t4_issue_timeout", n_acc - start, 20);
    drain();
    chk("t4_err", err, 0);

    // Protocol error: result with nothing pending
    force_res = 1'b1; force_data = 32'hDEADBEEF;
    res_valid = 1'b1; res_data = force_data;
    step();
    force_res = 1'b0; res_valid = 1'b0; res_data = '0;
    chk("t5_err", err, 1);
    chk("t5_wbv", wb_valid, 0);
    repeat (3) step();
    chk("t5_err_sticky", err, 1);
    chk("t5_wbv_hold", wb_valid, 0);

    // Reset with entries in flight
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_tag = 5'(20 + i); issue_in = 1000 * (i + 1);
      step();
    end
    issue_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_out", outstanding, 0);
    chk("t6_wbv", wb_valid, 0);
    chk("t6_ready", issue_ready, 1);
    chk("t6_err", err, 0);
    issue_valid = 1'b1; issue_tag = 5'd7; issue_in = 1;
    step();
    issue_valid = 1'b0;
    wait_wbv(10);
    chk("t6_tag", wb_tag, 7);
    chk("t6_data", wb_data, 32'h3F800000);
    drain();
    repeat (LAT + 2) step();
    chk("t6_err_after", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
